// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty-cycle controller front end.
//   btn_state_t : per-button sequencing states (idle / waiting for first repeat / repeating)
//   DEF_*       : default timing constants for a 100 MHz system clock
//   cnt_width() : counter width able to hold 0..max_val, never narrower than one bit
package pwm_ctrl_pkg;

   typedef enum logic [1:0] {
      BTN_IDLE      = 2'd0,
      BTN_HOLD_WAIT = 2'd1,
      BTN_REPEAT    = 2'd2
   } btn_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 50_000_000;
   localparam int DEF_REPEAT_PERIOD   = 10_000_000;
   localparam int DEF_PULSE_LEN       = 4;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_debounce_repeat.sv
// One push-button channel: 2-flop synchroniser, debounce filter and
// press / auto-repeat sequencer.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   raw          : raw asynchronous button input, active-high
//   level        : debounced stable level of the button
//   press_event  : single-cycle request, raised on the cycle the stable level
//                  rises and on every repeat tick while held
module button_debounce_repeat
   import pwm_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press_event
);

   localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int TW = cnt_width(TIMER_MAX);
   localparam bit REPEAT_EN = (REPEAT_DELAY != 0);
   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST  = REPEAT_EN ? TW'(REPEAT_DELAY - 1) : '0;
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   logic            sync1_reg;
   logic            sync2_reg;
   logic            stable_reg;
   logic [DW-1:0]   db_cnt_reg;
   btn_state_t      state_reg;
   logic [TW-1:0]   timer_reg;

   // Synchroniser and debounce: the counter only runs while the synchronised
   // input disagrees with the stable level, so any bounce back restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         db_cnt_reg <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + DW'(1);
         end
      end
   end

   // Press / repeat sequencer. The timer restarts on every state change;
   // with repeats disabled it parks in HOLD_WAIT with a frozen timer.
   always_ff @(posedge clk) begin
      if (rst || !stable_reg) begin
         state_reg <= BTN_IDLE;
         timer_reg <= '0;
      end else begin
         case (state_reg)
            BTN_IDLE: begin
               state_reg <= BTN_HOLD_WAIT;
               timer_reg <= '0;
            end
            BTN_HOLD_WAIT: begin
               if (REPEAT_EN && timer_reg == DELAY_LAST) begin
                  state_reg <= BTN_REPEAT;
                  timer_reg <= '0;
               end else if (REPEAT_EN) begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            BTN_REPEAT: begin
               if (timer_reg == PERIOD_LAST) begin
                  timer_reg <= '0;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            default: begin
               state_reg <= BTN_IDLE;
               timer_reg <= '0;
            end
         endcase
      end
   end

   // The request is decoded from state so that it appears in the same cycle
   // the stable level rises; the pulse stretcher downstream registers it.
   always_comb begin
      press_event = 1'b0;
      if (stable_reg) begin
         case (state_reg)
            BTN_IDLE:      press_event = 1'b1;
            BTN_HOLD_WAIT: press_event = REPEAT_EN && (timer_reg == DELAY_LAST);
            BTN_REPEAT:    press_event = (timer_reg == PERIOD_LAST);
            default:       press_event = 1'b0;
         endcase
      end
   end

   assign level = stable_reg;

endmodule

// File: rtl/duty_button_conditioner.sv
// Front end for the PWM duty-cycle controller: turns two raw bouncing buttons
// into clean fixed-width increase/decrease request pulses.
// Ports:
//   clk, rst                   : system clock, synchronous active-high reset
//   btn_inc_raw, btn_dec_raw   : raw asynchronous buttons, active-high
//   increase_duty, decrease_duty : registered PULSE_LEN-cycle request pulses
//   inc_level, dec_level       : debounced stable button levels
// Channel 0 is "increase", channel 1 is "decrease".
module duty_button_conditioner
   import pwm_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int PULSE_LEN       = DEF_PULSE_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_inc_raw,
   input  logic btn_dec_raw,
   output logic increase_duty,
   output logic decrease_duty,
   output logic inc_level,
   output logic dec_level
);

   localparam int SW = cnt_width(2 * PULSE_LEN);
   localparam logic [SW-1:0] HIGH_LAST = SW'(PULSE_LEN);
   localparam logic [SW-1:0] SPAN_LAST = SW'(2 * PULSE_LEN);

   logic [1:0] raw_vec;
   logic [1:0] level_vec;
   logic [1:0] event_vec;
   logic [1:0] pulse_vec;
   logic       lockout;

   assign raw_vec = {btn_dec_raw, btn_inc_raw};

   // Requests raised while both buttons are down are discarded; the
   // sequencers keep timing so repeats resume on their own schedule.
   assign lockout = level_vec[0] & level_vec[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          accept;
      logic [SW-1:0] cnt_reg;
      logic          pulse_reg;

      button_debounce_repeat #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_btn (
         .clk         (clk),
         .rst         (rst),
         .raw         (raw_vec[gi]),
         .level       (level_vec[gi]),
         .press_event (event_vec[gi])
      );

      assign accept = event_vec[gi] & ~lockout;

      // cnt_reg runs 1..2*PULSE_LEN over one pulse plus its low gap; the
      // terminal count doubles as "ready" so a request landing exactly when
      // the gap ends is still taken (back-to-back at 2*PULSE_LEN spacing).
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
         end else if ((cnt_reg == '0 || cnt_reg == SPAN_LAST) && accept) begin
            cnt_reg   <= SW'(1);
            pulse_reg <= 1'b1;
         end else if (cnt_reg == SPAN_LAST) begin
            cnt_reg <= '0;
         end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg + SW'(1);
            if (cnt_reg == HIGH_LAST) begin
               pulse_reg <= 1'b0;
            end
         end
      end

      assign pulse_vec[gi] = pulse_reg;
   end

   assign increase_duty = pulse_vec[0];
   assign decrease_duty = pulse_vec[1];
   assign inc_level     = level_vec[0];
   assign dec_level     = level_vec[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Scoreboard bench for duty_button_conditioner. Three instances share the same
// button stimulus: normal repeat timing, repeats disabled, and a repeat period
// equal to twice the pulse length. A time-based reference model predicts
// stable levels and pulse start cycles; a monitor compares on every cycle.
module tb_duty_button_conditioner;

   localparam int NI  = 3;
   localparam int DEB = 4;
   localparam int PL  = 2;
   localparam int RD_T [NI] = '{20, 0, 4};
   localparam int RP_T [NI] = '{10, 10, 4};

   typedef struct {
      int inst;
      int ch;
      int t;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inc_raw = 1'b0;
   logic dec_raw = 1'b0;

   logic dut_inc [NI];
   logic dut_dec [NI];
   logic lvl_inc [NI];
   logic lvl_dec [NI];

   int   chk = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   done = 1'b0;
   bit   drained = 1'b0;
   exp_t sb_q[$];

   // reference model state (values after the latest clock edge)
   int s1_m   [NI][2];
   int s2_m   [NI][2];
   int stab_m [NI][2];
   int mis_m  [NI][2];
   int held_m [NI][2];
   int press_m[NI][2];
   int last_m [NI][2];
   int pend_m [NI][2];
   int prev_o [NI][2];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      duty_button_conditioner #(
         .DEBOUNCE_CYCLES (DEB),
         .REPEAT_DELAY    (RD_T[gi]),
         .REPEAT_PERIOD   (RP_T[gi]),
         .PULSE_LEN       (PL)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .btn_inc_raw   (inc_raw),
         .btn_dec_raw   (dec_raw),
         .increase_duty (dut_inc[gi]),
         .decrease_duty (dut_dec[gi]),
         .inc_level     (lvl_inc[gi]),
         .dec_level     (lvl_dec[gi])
      );
   end

   // Reference model: stable level follows the synchronised input after DEB
   // consecutive disagreeing cycles; requests occur at press time p, p+RD and
   // every RP after that while held; a request is dropped under lockout or
   // if fewer than 2*PL cycles passed since the previous pulse start; the
   // pulse starts one cycle after an accepted request.
   always @(posedge clk) begin
      int rv;
      int h;
      int ev;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < 2; c++) begin
            rv = (c == 0) ? int'(inc_raw) : int'(dec_raw);
            if (rst) begin
               s1_m[i][c] = 0; s2_m[i][c] = 0; stab_m[i][c] = 0; mis_m[i][c] = 0;
               held_m[i][c] = 0; pend_m[i][c] = 0; last_m[i][c] = -1000;
            end else begin
               if (pend_m[i][c] != 0) begin
                  sb_q.push_back('{i, c, cyc});
                  last_m[i][c] = cyc;
                  pend_m[i][c] = 0;
               end
               if (s2_m[i][c] != stab_m[i][c]) begin
                  mis_m[i][c]++;
                  if (mis_m[i][c] == DEB) begin
                     stab_m[i][c] = s2_m[i][c];
                     mis_m[i][c] = 0;
                  end
               end else begin
                  mis_m[i][c] = 0;
               end
               s2_m[i][c] = s1_m[i][c];
               s1_m[i][c] = rv;
            end
         end
         if (!rst) begin
            for (int c = 0; c < 2; c++) begin
               ev = 0;
               if (stab_m[i][c] != 0) begin
                  if (held_m[i][c] == 0) begin
                     press_m[i][c] = cyc;
                     ev = 1;
                  end else begin
                     h = cyc - press_m[i][c];
                     if (RD_T[i] > 0 && h >= RD_T[i] && ((h - RD_T[i]) % RP_T[i]) == 0) ev = 1;
                  end
               end
               held_m[i][c] = stab_m[i][c];
               if (ev != 0 && !(stab_m[i][0] != 0 && stab_m[i][1] != 0) &&
                   (cyc + 1 - last_m[i][c] >= 2 * PL)) begin
                  pend_m[i][c] = 1;
               end
            end
         end
      end
   end

   // Monitor: compares levels and output levels every cycle, pops the
   // scoreboard on each rising pulse and flags any predicted pulse not seen.
   always @(negedge clk) begin
      int o;
      int l;
      int e;
      int idx;
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < 2; c++) begin
            o = (c == 0) ? int'(dut_inc[i]) : int'(dut_dec[i]);
            l = (c == 0) ? int'(lvl_inc[i]) : int'(lvl_dec[i]);
            e = (last_m[i][c] >= 0 && cyc >= last_m[i][c] && cyc - last_m[i][c] < PL) ? 1 : 0;
            chk++;
            if (l != stab_m[i][c]) begin
               fails++;
               $display("FAIL level inst=%0d ch=%0d cyc=%0d got=%0d required=%0d", i, c, cyc, l, stab_m[i][c]);
            end
            chk++;
            if (o != e) begin
               fails++;
               $display("FAIL pulse_level inst=%0d ch=%0d cyc=%0d got=%0d required=%0d", i, c, cyc, o, e);
            end
            if (o != 0 && prev_o[i][c] == 0) begin
               idx = -1;
               for (int k = 0; k < sb_q.size(); k++) begin
                  if (idx < 0 && sb_q[k].inst == i && sb_q[k].ch == c) idx = k;
               end
               chk++;
               if (idx < 0) begin
                  fails++;
                  $display("FAIL unexpected_pulse inst=%0d ch=%0d got_start=%0d required=none", i, c, cyc);
               end else begin
                  if (sb_q[idx].t != cyc) begin
                     fails++;
                     $display("FAIL pulse_start inst=%0d ch=%0d got=%0d required=%0d", i, c, cyc, sb_q[idx].t);
                  end else begin
                     $display("pulse inst=%0d ch=%0d start=%0d required=%0d", i, c, cyc, sb_q[idx].t);
                  end
                  sb_q.delete(idx);
               end
            end
            prev_o[i][c] = o;
         end
      end
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
         if (sb_q[k].t < cyc) begin
            chk++;
            fails++;
            $display("FAIL missing_pulse inst=%0d ch=%0d got=none required=%0d", sb_q[k].inst, sb_q[k].ch, sb_q[k].t);
            sb_q.delete(k);
         end
      end
      if (done && !drained) begin
         drained = 1'b1;
         chk++;
         if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain got_pending=%0d required=0", sb_q.size());
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      int seg;
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < 2; c++) prev_o[i][c] = 0;
      rst = 1'b1; inc_raw = 1'b0; dec_raw = 1'b0;
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(5);

      // bounce then a clean hold
      for (int k = 0; k < 10; k++) begin
         inc_raw = ~inc_raw;
         wait_cycles(2);
      end
      inc_raw = 1'b1;
      wait_cycles(8);
      inc_raw = 1'b0;
      wait_cycles(20);

      // long hold on decrease: first pulse plus repeats
      dec_raw = 1'b1;
      wait_cycles(55);
      dec_raw = 1'b0;
      wait_cycles(20);

      // short glitch must be filtered
      inc_raw = 1'b1;
      wait_cycles(3);
      inc_raw = 1'b0;
      wait_cycles(15);

      // lockout: decrease pressed while increase is held
      inc_raw = 1'b1;
      n = 0;
      while (!lvl_inc[0] && n < 20) begin
         wait_cycles(1);
         n++;
      end
      chk++;
      if (n >= 20) begin
         fails++;
         $display("FAIL lockout_wait got=timeout required=inc_level");
      end
      wait_cycles(5);
      dec_raw = 1'b1;
      wait_cycles(40);
      dec_raw = 1'b0;
      wait_cycles(35);
      inc_raw = 1'b0;
      wait_cycles(20);

      // reset while a pulse is high and the button is held
      inc_raw = 1'b1;
      n = 0;
      while (!dut_inc[0] && n < 30) begin
         wait_cycles(1);
         n++;
      end
      chk++;
      if (n >= 30) begin
         fails++;
         $display("FAIL reset_wait got=timeout required=increase_duty");
      end
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      wait_cycles(20);
      inc_raw = 1'b0;
      wait_cycles(20);

      // long hold: repeats disabled / back-to-back repeat instances
      inc_raw = 1'b1;
      wait_cycles(100);
      inc_raw = 1'b0;
      wait_cycles(20);

      // randomized segments with occasional resets
      for (seg = 0; seg < 60; seg++) begin
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            wait_cycles(1);
            rst = 1'b0;
         end
         inc_raw = 1'($urandom_range(0, 1));
         dec_raw = 1'($urandom_range(0, 1));
         wait_cycles(int'($urandom_range(1, 35)));
      end
      inc_raw = 1'b0;
      dec_raw = 1'b0;
      wait_cycles(40);
      done = 1'b1;
      wait_cycles(3);
      $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
      $finish;
   end

endmodule
